// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared defaults, FSM state enum and FIFO entry type for the MVM output drain
// Purpose: common definitions imported by mvm_out_drain and its FIFO.
package mvm_pkg;

  localparam int K_DEF     = 8;
  localparam int B_DEF     = 8;
  localparam int SHIFT_DEF = 4;
  localparam int DEPTH_DEF = 2 * K_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    CAPTURE = 2'd2,
    DROP    = 2'd3
  } drain_state_t;

  // One FIFO slot at the default operand width: {last, data}.
  typedef struct packed {
    logic             last;
    logic [B_DEF-1:0] data;
  } drain_entry_t;

endpackage

// File: rtl/mvm_drain_fifo.sv
// rtl/mvm_drain_fifo.sv - single-clock FIFO holding requantised elements
// Purpose: buffers {last, data} entries between capture and the consumer.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i/push_data_i write one entry (caller guarantees space)
//   pop_i              remove head entry (ignored when empty)
//   head_data_o        head entry, zero when empty
//   empty_o, count_o   occupancy
module mvm_drain_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_data_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  assign empty_o     = (count_q == '0);
  assign do_pop      = pop_i && !empty_o;
  assign count_o     = count_q;
  assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; head_data_o is masked while empty instead.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mvm_out_drain.sv
// rtl/mvm_out_drain.sv - captures an MVM result vector, requantises it and queues it for a consumer
// Purpose: on a done rise, capture K results, round/shift/ReLU/saturate to B bits, buffer in a FIFO.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   mvm_done, mvm_data      done level and 2*B-bit signed result stream
//   relu_en                 clamp negatives to zero, sampled per element
//   out_valid/out_ready     output handshake; out_data, out_last are the FIFO head
//   busy, sat_flag          not-IDLE status, sticky saturation flag
//   drop_cnt                saturating count of vectors dropped for lack of space
module mvm_out_drain
  import mvm_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int B     = B_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int DEPTH = 2 * K
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mvm_done,
  input  logic [2*B-1:0] mvm_data,
  input  logic           relu_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [B-1:0]   out_data,
  output logic           out_last,
  output logic           busy,
  output logic           sat_flag,
  output logic [7:0]     drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(K + 1);
  // Largest occupancy that still leaves room for a full vector.
  localparam logic [AW:0]      ADMIT_MAX = (AW+1)'(DEPTH - K);
  localparam logic signed [2*B:0] RND  = {{(2*B){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [2*B:0] MAXV = {{(B+2){1'b0}}, {(B-1){1'b1}}};
  localparam logic signed [2*B:0] MINV = {{(B+2){1'b1}}, {(B-1){1'b0}}};

  drain_state_t   state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           done_q;
  logic           sat_q;
  logic [7:0]     drop_q;
  logic           done_rise, push, drop_inc;
  logic [AW:0]    fifo_count;
  logic           fifo_empty;
  logic [B:0]     head;

  logic signed [2*B:0] sum, r_full, r_relu;
  logic [B-1:0]        q_data;
  logic                clamp;

  assign done_rise = mvm_done && !done_q;

  // Requantiser: sign-extend one bit so rounding cannot overflow.
  always_comb begin
    sum    = $signed({mvm_data[2*B-1], mvm_data}) + RND;
    r_full = sum >>> SHIFT;
    r_relu = (relu_en && (r_full < 0)) ? '0 : r_full;
    clamp  = 1'b0;
    q_data = r_relu[B-1:0];
    if (r_relu > MAXV) begin
      q_data = MAXV[B-1:0];
      clamp  = 1'b1;
    end else if (r_relu < MINV) begin
      q_data = MINV[B-1:0];
      clamp  = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    push     = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (done_rise) state_d = (fifo_count <= ADMIT_MAX) ? ALIGN : DROP;
      end
      ALIGN: begin
        idx_d   = '0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        push = 1'b1;
        if (idx_q == IW'(K - 1)) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DROP: begin
        // idx runs 0..K, giving K+1 cycles in this state.
        if (idx_q == IW'(K)) begin
          idx_d    = '0;
          drop_inc = 1'b1;
          state_d  = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= mvm_done;
      if (push && clamp) sat_q <= 1'b1;
      if (drop_inc && (drop_q != 8'hFF)) drop_q <= drop_q + 1'b1;
    end
  end

  mvm_drain_fifo #(
    .W     (B + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (push),
    .push_data_i ({(idx_q == IW'(K - 1)), q_data}),
    .pop_i       (out_ready),
    .head_data_o (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = head[B];
  assign out_data  = head[B-1:0];
  assign busy      = (state_q != IDLE);
  assign sat_flag  = sat_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_mvm_out_drain.sv
// tb/tb_mvm_out_drain.sv - scoreboard testbench for mvm_out_drain
module tb_mvm_out_drain;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mvm_done = 1'b0;
  logic [15:0] mvm_data = '0;
  logic        relu_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        sat_flag;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [8:0]  sb [$];
  logic [15:0] ys [8];

  mvm_out_drain dut (
    .clk       (clk),
    .reset     (reset),
    .mvm_done  (mvm_done),
    .mvm_data  (mvm_data),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .sat_flag  (sat_flag),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every accepted element must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got last=%0b data=%0d, required no output",
                 out_last, $signed(out_data));
      end else begin
        logic [8:0] exp;
        exp = sb.pop_front();
        if ({out_last, out_data} !== exp) begin
          errors++;
          $display("FAIL sb_element: got last=%0b data=%0d, required last=%0b data=%0d",
                   out_last, $signed(out_data), exp[8], $signed(exp[7:0]));
        end
      end
    end
  end

  task automatic expect_elem(input int v, input bit last);
    sb.push_back({last, 8'(v)});
  endtask

  task automatic wait_empty(input int max_cycles);
    for (int c = 0; c < max_cycles && sb.size() != 0; c++) @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  // Raises done so the next edge is N, then presents ys[i] for edge N+2+i.
  task automatic send_vector(input bit relu, input bit glitch, input int abort_at, output int lat);
    lat = -1;
    @(posedge clk); #1;
    mvm_done = 1'b1;
    relu_en  = relu;
    @(posedge clk); #1;
    if (out_valid && lat < 0) lat = 0;
    @(posedge clk); #1;
    if (out_valid && lat < 0) lat = 1;
    for (int i = 0; i < 8; i++) begin
      mvm_data = ys[i];
      if (glitch && i >= 1 && i <= 4) mvm_done = (i % 2 == 0);
      @(posedge clk); #1;
      if (out_valid && lat < 0) lat = i + 2;
      if (i == abort_at) begin
        reset = 1'b0;
        return;
      end
    end
    mvm_done = 1'b0;
    mvm_data = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b, required 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %0b, required 0", out_last); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL rst_data: got %0d, required 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b, required 0", busy); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL rst_sat: got %0b, required 0", sat_flag); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d, required 0", drop_cnt); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_relu();
    int lat;
    ys = '{16'hFFD8, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    expect_elem(0, 0); expect_elem(1, 0);
    for (int i = 2; i < 8; i++) expect_elem(0, i == 7);
    out_ready = 1'b1;
    send_vector(1'b1, 1'b0, -1, lat);
    wait_empty(40);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL relu_drain: got %0d left, required 0", sb.size()); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL relu_sat: got %0b, required 0", sat_flag); end
  endtask

  task automatic test_rounding();
    int lat;
    ys = '{16'd56, 16'hFFD8, 16'd3000, 16'hF448, 16'd0, 16'd0, 16'd0, 16'd0};
    expect_elem(4, 0); expect_elem(-2, 0); expect_elem(127, 0); expect_elem(-128, 0);
    for (int i = 4; i < 8; i++) expect_elem(0, i == 7);
    send_vector(1'b0, 1'b0, -1, lat);
    wait_empty(40);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL round_drain: got %0d left, required 0", sb.size()); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL round_sat: got %0b, required 1", sat_flag); end
  endtask

  task automatic test_full_vector();
    int lat;
    for (int i = 0; i < 8; i++) begin
      ys[i] = 16'(16 * i);
      expect_elem(i, i == 7);
    end
    send_vector(1'b0, 1'b0, -1, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL full_latency: got edge N+%0d, required N+2", lat); end
    wait_empty(40);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_drain: got %0d left, required 0", sb.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy: got %0b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b0;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 8; i++) begin
        ys[i] = 16'(16 * (i + 8 * v) + 16);
        if (v < 2) expect_elem(i + 8 * v + 1, i == 7);
      end
      send_vector(1'b0, 1'b0, -1, lat);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL bp_drop: got %0d, required 1", drop_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy: got %0b, required 0", busy); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b, required 1", out_valid); end
    checks++; if (out_data !== 8'd1 || out_last !== 1'b0) begin errors++; $display("FAIL bp_hold: got data=%0d last=%0b, required data=1 last=0", out_data, out_last); end
    out_ready = 1'b1;
    wait_empty(60);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left, required 0", sb.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b, required 0", out_valid); end
  endtask

  task automatic test_reset_mid_capture();
    int lat;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) ys[i] = 16'(16 * i + 16);
    send_vector(1'b0, 1'b0, 3, lat);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b, required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b, required 0", busy); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL mid_drop: got %0d, required 0", drop_cnt); end
    mvm_done = 1'b0;
    mvm_data = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      ys[i] = 16'(16 * i + 32);
      expect_elem(i + 2, i == 7);
    end
    send_vector(1'b0, 1'b0, -1, lat);
    wait_empty(40);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL mid_recapture: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_glitch();
    int lat;
    for (int i = 0; i < 8; i++) begin
      ys[i] = 16'(-16 * i);
      expect_elem(-i, i == 7);
    end
    send_vector(1'b0, 1'b1, -1, lat);
    wait_empty(40);
    repeat (12) @(posedge clk);
    #1;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL glitch_drain: got %0d left, required 0", sb.size()); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL glitch_drop: got %0d, required 0", drop_cnt); end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL glitch_extra: got busy=%0b valid=%0b, required 0 0", busy, out_valid); end
  endtask

  initial begin
    test_reset();
    test_relu();
    test_rounding();
    test_full_vector();
    test_back_to_back();
    test_reset_mid_capture();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
